// File: rtl/pwm_pkg.sv
// Shared types and default widths for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned N_CH_DEF = 4;
  localparam int unsigned CW_DEF   = 8;
  localparam int unsigned DT_W_DEF = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTRE = 1'b1
  } pwm_mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: active duty register, compare against the shared counter,
// registered output. With PWM_DEADTIME_EN defined a dead-time stage drives a
// complementary output and keeps both sides low for dead_time cycles per edge.
module pwm_ch
  import pwm_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DT_W = DT_W_DEF
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          commit,
  input  logic [CW-1:0] duty_sh,
  input  logic [CW-1:0] cnt,
  output logic          pwm_o
`ifdef PWM_DEADTIME_EN
  , input  logic [DT_W-1:0] dead_time
  , output logic            pwm_n_o
`endif
);

  logic [CW-1:0] duty_q;
  logic          raw_c;

  // D=0 never matches, D>P always matches: no special cases needed
  assign raw_c = (cnt < duty_q);

  // Active duty only changes on a commit, which lines up with cnt returning to 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      duty_q <= '0;
    end else if (commit) begin
      duty_q <= duty_sh;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic            lvl_q;
  logic [DT_W-1:0] dt_q;
  logic [DT_W-1:0] dt_d;
  logic            busy_c;

  // Dead-time counter reloads on every raw edge so short pulses are swallowed
  always_comb begin
    dt_d = dt_q;
    if (!en) begin
      dt_d = '0;
    end else if (raw_c != lvl_q) begin
      dt_d = dead_time;
    end else if (dt_q != '0) begin
      dt_d = dt_q - DT_W'(1);
    end
  end

  assign busy_c = (dt_d != '0);

  // Both sides held low while the dead-time window is open
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lvl_q   <= 1'b0;
      dt_q    <= '0;
      pwm_o   <= 1'b0;
      pwm_n_o <= 1'b0;
    end else begin
      lvl_q   <= en & raw_c;
      dt_q    <= dt_d;
      pwm_o   <= en & raw_c & ~busy_c;
      pwm_n_o <= en & ~raw_c & ~busy_c;
    end
  end
`else
  // Output is the compare result delayed by exactly one cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= en & raw_c;
    end
  end
`endif

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM generator: shared period counter (edge or centre aligned),
// shadow registers committed only at a period boundary (or immediately while
// disabled), and one pwm_ch per channel. Optional macro PWM_DEADTIME_EN adds
// the dead_time input and complementary pwm_n_o outputs.
module pwm_multi_ch
  import pwm_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  parameter int unsigned CW   = CW_DEF
`ifdef PWM_DEADTIME_EN
  , parameter int unsigned DT_W = DT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             mode,
  input  logic [CW-1:0]    period,
  input  logic [N_CH*CW-1:0] duty,
  input  logic             upd_req,
  output logic             upd_pend,
  output logic             period_end,
  output logic [N_CH-1:0]  pwm_o
`ifdef PWM_DEADTIME_EN
  , input  logic [DT_W-1:0] dead_time
  , output logic [N_CH-1:0] pwm_n_o
`endif
);

  logic [CW-1:0]      cnt_q, cnt_d;
  pwm_dir_t           dir_q, dir_d;
  logic [CW-1:0]      per_act_q, per_d;
  pwm_mode_t          mode_act_q, mode_d;
  logic [CW-1:0]      per_sh_q;
  pwm_mode_t          mode_sh_q;
  logic [N_CH*CW-1:0] duty_sh_q;
  logic               commit_c;
  logic               pend_d;
  logic               period_end_d;

  // True on the final count of a period for the given counter state
  function automatic logic is_last(input logic [CW-1:0] c, input pwm_dir_t d,
                                   input logic [CW-1:0] p, input pwm_mode_t m);
    if (m == PWM_EDGE) begin
      return c >= p;
    end else if (d == DIR_UP) begin
      return (c >= p) && (p <= CW'(1));
    end else begin
      return c <= CW'(1);
    end
  endfunction

  // Counter sequencing, commit decision and next-cycle period_end
  always_comb begin
    commit_c = upd_pend && (period_end || !en);
    per_d    = commit_c ? per_sh_q  : per_act_q;
    mode_d   = commit_c ? mode_sh_q : mode_act_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (is_last(cnt_q, dir_q, per_act_q, mode_act_q)) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act_q == PWM_EDGE) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= per_act_q) begin
        cnt_d = per_act_q - CW'(1);
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
    pend_d       = upd_req || (upd_pend && !commit_c);
    period_end_d = en && is_last(cnt_d, dir_d, per_d, mode_d);
  end

  // Counter, active/shadow configuration and status registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dir_q      <= DIR_UP;
      per_act_q  <= '0;
      mode_act_q <= PWM_EDGE;
      per_sh_q   <= '0;
      mode_sh_q  <= PWM_EDGE;
      duty_sh_q  <= '0;
      upd_pend   <= 1'b0;
      period_end <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      per_act_q  <= per_d;
      mode_act_q <= mode_d;
      upd_pend   <= pend_d;
      period_end <= period_end_d;
      if (upd_req) begin
        per_sh_q  <= period;
        mode_sh_q <= pwm_mode_t'(mode);
        duty_sh_q <= duty;
      end
    end
  end

  // Per-channel compare and output stage
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_ch #(
      .CW (CW)
`ifdef PWM_DEADTIME_EN
      , .DT_W (DT_W)
`endif
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .commit  (commit_c),
      .duty_sh (duty_sh_q[k*CW +: CW]),
      .cnt     (cnt_q),
      .pwm_o   (pwm_o[k])
`ifdef PWM_DEADTIME_EN
      , .dead_time (dead_time)
      , .pwm_n_o   (pwm_n_o[k])
`endif
    );
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: phase-based reference model checked every cycle,
// directed scenarios pinned with hand-computed counts, then random traffic.
module tb_pwm_multi_ch;

  localparam int unsigned N_CH = 4;
  localparam int unsigned CW   = 8;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               en;
  logic               mode;
  logic [CW-1:0]      period;
  logic [N_CH*CW-1:0] duty;
  logic               upd_req;
  logic               upd_pend;
  logic               period_end;
  logic [N_CH-1:0]    pwm_o;
`ifdef PWM_DEADTIME_EN
  logic [3:0]         dead_time;
  logic [N_CH-1:0]    pwm_n_o;
`endif

  int checks = 0;
  int errors = 0;

  pwm_multi_ch #(.N_CH(N_CH), .CW(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .mode       (mode),
    .period     (period),
    .duty       (duty),
    .upd_req    (upd_req),
    .upd_pend   (upd_pend),
    .period_end (period_end),
    .pwm_o      (pwm_o)
`ifdef PWM_DEADTIME_EN
    , .dead_time (dead_time)
    , .pwm_n_o   (pwm_n_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse-count checks assume plain outputs (no dead-time shortening)
  task automatic chk_hi(input string name, input int act, input int exp);
`ifndef PWM_DEADTIME_EN
    chk(name, act, exp);
`endif
  endtask

  // ---------------- reference model: position within period ----------------
  int          m_ph;
  int          m_P, m_sP;
  bit          m_mode, m_smode;
  int          m_D[N_CH];
  int          m_sD[N_CH];
  bit          m_pend, m_pe;
  logic [N_CH-1:0] m_pwm;

  function automatic int plen(input int p, input bit centre);
    if (!centre) return p + 1;
    return (p == 0) ? 1 : 2 * p;
  endfunction

  function automatic int pcnt(input int ph, input int p, input bit centre);
    if (!centre || ph <= p) return ph;
    return 2 * p - ph;
  endfunction

  task automatic model_step();
    int  len, c, nph;
    bit  commit, last;
    if (!reset_n) begin
      m_ph = 0; m_P = 0; m_sP = 0; m_mode = 0; m_smode = 0;
      for (int k = 0; k < N_CH; k++) begin m_D[k] = 0; m_sD[k] = 0; end
      m_pend = 0; m_pe = 0; m_pwm = '0;
    end else begin
      len  = plen(m_P, m_mode);
      c    = pcnt(m_ph, m_P, m_mode);
      last = (m_ph == len - 1);
      for (int k = 0; k < N_CH; k++) m_pwm[k] = en && (c < m_D[k]);
      commit = m_pend && (m_pe || !en);
      nph = (!en || last) ? 0 : m_ph + 1;
      if (commit) begin
        m_P = m_sP; m_mode = m_smode;
        for (int k = 0; k < N_CH; k++) m_D[k] = m_sD[k];
      end
      if (upd_req) begin
        m_sP = int'(period); m_smode = mode;
        for (int k = 0; k < N_CH; k++) m_sD[k] = int'(duty[k*CW +: CW]);
        m_pend = 1;
      end else if (commit) begin
        m_pend = 0;
      end
      m_ph = nph;
      m_pe = en && (m_ph == plen(m_P, m_mode) - 1);
    end
  endtask

  // Advance the model on each edge, then compare once the DUT has settled
  always @(posedge clk) begin
    model_step();
    #1;
`ifdef PWM_DEADTIME_EN
    chk("no_overlap", int'(pwm_o & pwm_n_o), 0);
`else
    chk("pwm_o", int'(pwm_o), int'(m_pwm));
`endif
    chk("period_end", int'(period_end), int'(m_pe));
    chk("upd_pend", int'(upd_pend), int'(m_pend));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_upd(input int p, input bit md, input int d0, input int d1,
                        input int d2, input int d3);
    period = CW'(p);
    mode   = md;
    duty[0*CW +: CW] = CW'(d0);
    duty[1*CW +: CW] = CW'(d1);
    duty[2*CW +: CW] = CW'(d2);
    duty[3*CW +: CW] = CW'(d3);
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
  endtask

  task automatic wait_pend(input string name);
    int n = 0;
    while (upd_pend && n < 600) begin tick(); n++; end
    chk(name, int'(upd_pend), 0);
  endtask

  task automatic wait_hi(input string name);
    int n = 0;
    while (!pwm_o[0] && n < 100) begin tick(); n++; end
    chk(name, int'(pwm_o[0]), 1);
  endtask

  task automatic count_win(input int n, input int ch, output int hi, output int pe);
    hi = 0; pe = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      hi += int'(pwm_o[ch]);
      pe += int'(period_end);
    end
  endtask

  int hi, pe, d;

  initial begin
    reset_n = 1'b0; en = 1'b0; mode = 1'b0; upd_req = 1'b0;
    period = '0; duty = '0;
`ifdef PWM_DEADTIME_EN
    dead_time = 4'd2;
`endif
    repeat (3) tick();
    chk("rst_pwm", int'(pwm_o), 0);
    chk("rst_pe", int'(period_end), 0);
    chk("rst_pend", int'(upd_pend), 0);
    reset_n = 1'b1;

    // Edge mode P=9: ch0 3/10, ch2 9/10, ch3 D>P stays high
    do_upd(9, 0, 3, 0, 9, 10);
    chk("t1_pend_set", int'(upd_pend), 1);
    tick();
    chk("t1_pend_commit_disabled", int'(upd_pend), 0);
    en = 1'b1;
    repeat (15) tick();
    count_win(10, 0, hi, pe);
    chk_hi("t1_ch0_high", hi, 3);
    chk("t1_pe_count", pe, 1);
    count_win(10, 3, hi, pe);
    chk_hi("t1_ch3_full", hi, 10);

    // D=0 and D=200 with P=99: constant levels across the wrap
    do_upd(99, 0, 0, 200, 50, 99);
    repeat (30) tick();
    count_win(100, 0, hi, pe);
    chk_hi("t2_ch0_zero", hi, 0);
    chk("t2_pe_count", pe, 1);
    count_win(100, 1, hi, pe);
    chk_hi("t2_ch1_full", hi, 100);

    // Centre mode P=4, D=2: 8-cycle period, high for cnt 1,0,1
    do_upd(4, 1, 2, 0, 4, 5);
    wait_pend("t3_commit_timeout");
    repeat (10) tick();
    count_win(16, 0, hi, pe);
    chk_hi("t3_ch0_high", hi, 6);
    chk("t3_pe_count", pe, 2);

    // Two updates inside one period: last write wins at the boundary
    do_upd(9, 0, 3, 1, 2, 3);
    wait_pend("t4_first_timeout");
    repeat (2) tick();
    do_upd(9, 0, 7, 1, 2, 3);
    chk("t4_pend_first", int'(upd_pend), 1);
    do_upd(9, 0, 5, 1, 2, 3);
    chk("t4_pend_second", int'(upd_pend), 1);
    wait_pend("t4_commit_timeout");
    count_win(10, 0, hi, pe);
    chk_hi("t4_ch0_high", hi, 5);
    chk("t4_pe_count", pe, 1);

    // en dropped mid-pulse with an update pending
    wait_hi("t5_pulse_timeout");
    do_upd(9, 0, 2, 1, 2, 3);
    chk("t5_pend_before", int'(upd_pend), 1);
    en = 1'b0;
    tick();
    chk("t5_pwm_off", int'(pwm_o), 0);
    chk("t5_pend_cleared", int'(upd_pend), 0);
    chk("t5_pe_off", int'(period_end), 0);
    en = 1'b1;
    count_win(10, 0, hi, pe);
    chk_hi("t5_ch0_new_duty", hi, 2);
    chk("t5_pe_count", pe, 1);

    // Reset in the middle of a period with an update pending
    do_upd(7, 1, 3, 3, 3, 3);
    repeat (2) tick();
    reset_n = 1'b0;
    tick();
    chk("t6_rst_pwm", int'(pwm_o), 0);
    chk("t6_rst_pe", int'(period_end), 0);
    chk("t6_rst_pend", int'(upd_pend), 0);
    reset_n = 1'b1;

`ifdef PWM_DEADTIME_EN
    // Dead time 2, P=9, D=4: pwm_o high 2 cycles, pwm_n_o high 4 cycles
    do_upd(9, 0, 4, 4, 4, 4);
    wait_pend("dt_commit_timeout");
    repeat (12) tick();
    hi = 0; d = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi += int'(pwm_o[0]);
      d  += int'(pwm_n_o[0]);
    end
    chk("dt_pwm_high", hi, 2);
    chk("dt_pwm_n_high", d, 4);
`endif

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      reset_n = ($urandom_range(0, 599) != 0);
      en      = ($urandom_range(0, 19) != 0);
      upd_req = ($urandom_range(0, 9) == 0);
      if (upd_req) begin
        case ($urandom_range(0, 9))
          0:       period = CW'(0);
          1:       period = CW'(1);
          2:       period = CW'(2);
          3:       period = CW'(255);
          default: period = CW'($urandom_range(3, 20));
        endcase
        mode = 1'($urandom_range(0, 1));
        for (int k = 0; k < N_CH; k++) begin
          case ($urandom_range(0, 4))
            0:       d = 0;
            1:       d = 255;
            2:       d = int'(period);
            3:       d = (period == CW'(255)) ? 255 : int'(period) + 1;
            default: d = int'($urandom_range(0, 21));
          endcase
          duty[k*CW +: CW] = CW'(d);
        end
      end
      tick();
    end
    upd_req = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
